// File: rtl/dstack_spill_control.sv
// Data-stack spill/fill sequencer: tracks on-chip occupancy and moves the bottom
// entry to/from a memory overflow region around high/low water marks.
module dstack_spill_control #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int HIGH_WATER = 56,
  parameter int LOW_WATER = 8,
  parameter logic [WORD_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          step_valid,
  input  logic [1:0]                    movement,
  output logic                          step_ready,
  input  logic [WORD_WIDTH-1:0]         bottom_value,
  output logic                          spill_pop,
  output logic                          fill_push,
  output logic [WORD_WIDTH-1:0]         fill_value,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [WORD_WIDTH-1:0]         mem_addr,
  output logic [WORD_WIDTH-1:0]         mem_wdata,
  input  logic                          mem_ack,
  input  logic [WORD_WIDTH-1:0]         mem_rdata,
  output logic [$clog2(DEPTH+1)-1:0]    depth,
  output logic [WORD_WIDTH-1:0]         mem_count,
  output logic                          underflow
);
  localparam int DW = $clog2(DEPTH+1);
  localparam logic [DW-1:0] HIGH_D  = DW'(HIGH_WATER);
  localparam logic [DW-1:0] LOW_D   = DW'(LOW_WATER);
  localparam logic [DW-1:0] FULL_D  = DW'(DEPTH);
  localparam logic [DW-1:0] FULL_M1 = DW'(DEPTH - 1);
  localparam logic [DW-1:0] ONE_D   = DW'(1);
  localparam logic [DW-1:0] TWO_D   = DW'(2);
  localparam logic [WORD_WIDTH-1:0] ONE_W = WORD_WIDTH'(1);
  localparam logic signed [DW+1:0] S_ONE = (DW+2)'(1);
  localparam logic signed [DW+1:0] S_TWO = (DW+2)'(2);

  typedef enum logic [1:0] {IDLE, SPILL_WAIT, FILL_WAIT} state_t;

  state_t                  state, state_next;
  logic [WORD_WIDTH-1:0]   mem_sp;
  logic                    start_spill, start_fill;
  logic                    accept, push, pop1, pop2, short_pop;
  logic [DW-1:0]           pop_n;
  logic signed [DW+1:0]    depth_sum;
  logic [DW-1:0]           depth_next;

  // Clamp the signed occupancy sum at zero (underflowing pops saturate).
  function automatic logic [DW-1:0] sat_depth(input logic signed [DW+1:0] v);
    if (v < 0) return '0;
    return v[DW-1:0];
  endfunction

  assign pop_n     = movement[0] ? TWO_D : ONE_D;
  assign short_pop = depth < pop_n;
  assign accept    = step_valid & step_ready;
  assign push      = accept & (movement == 2'b01);
  assign pop1      = accept & (movement == 2'b10);
  assign pop2      = accept & (movement == 2'b11);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_spill = 1'b0;
    start_fill  = 1'b0;
    unique case (state)
      IDLE: begin
        if (depth >= HIGH_D && mem_count != '1) begin
          state_next  = SPILL_WAIT;
          start_spill = 1'b1;
        end else if (depth < LOW_D && mem_count != '0) begin
          state_next = FILL_WAIT;
          start_fill = 1'b1;
        end
      end
      SPILL_WAIT: if (mem_ack) state_next = IDLE;
      FILL_WAIT:  if (mem_ack) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    spill_pop  = (state == SPILL_WAIT) && mem_ack;
    fill_push  = (state == FILL_WAIT) && mem_ack;
    fill_value = fill_push ? mem_rdata : '0;
    step_ready = 1'b1;
    unique case (movement)
      2'b00: step_ready = 1'b1;
      // A pending fill will occupy one slot, so keep it free.
      2'b01: step_ready = (state == FILL_WAIT) ? (depth < FULL_M1) : (depth < FULL_D);
      default: begin
        if (short_pop)                step_ready = (mem_count == '0);
        else if (state == SPILL_WAIT) step_ready = depth > pop_n;
        else                          step_ready = 1'b1;
      end
    endcase
  end

  always_comb begin
    depth_sum = $signed({2'b00, depth});
    if (push)      depth_sum = depth_sum + S_ONE;
    if (fill_push) depth_sum = depth_sum + S_ONE;
    if (spill_pop) depth_sum = depth_sum - S_ONE;
    if (pop1)      depth_sum = depth_sum - S_ONE;
    if (pop2)      depth_sum = depth_sum - S_TWO;
    depth_next = sat_depth(depth_sum);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_sp    <= BASE_ADDR;
      mem_count <= '0;
      depth     <= '0;
      underflow <= 1'b0;
    end else begin
      if (start_spill) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= mem_sp;
        mem_wdata <= bottom_value;
      end else if (start_fill) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= mem_sp - ONE_W;
      end else if (mem_ack && state != IDLE) begin
        mem_req <= 1'b0;
      end
      if (spill_pop) begin
        mem_sp    <= mem_sp + ONE_W;
        mem_count <= mem_count + ONE_W;
      end else if (fill_push) begin
        mem_sp    <= mem_sp - ONE_W;
        mem_count <= mem_count - ONE_W;
      end
      depth <= depth_next;
      if ((pop1 || pop2) && short_pop) underflow <= 1'b1;
    end
  end
endmodule
